// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and helpers for the fifo_rr_arbiter block.
// No logic of its own: state encoding, stats counter width, pointer wrap.
package fifo_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int STAT_WIDTH = 32;

    // Next round-robin start position after idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set req bit at or after ptr, wrapping around.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rr_priority_picker #(
    parameter  int NUM_IN    = 4,
    localparam int SEL_WIDTH = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0]    req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] idx
);

    logic [2*NUM_IN-1:0]  dbl;
    logic [SEL_WIDTH-1:0] off;
    logic [SEL_WIDTH:0]   sum;

    always_comb begin
        // Rotating the doubled vector puts requester ptr at bit 0.
        dbl   = {req, req} >> ptr;
        found = 1'b0;
        off   = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                off   = SEL_WIDTH'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (SEL_WIDTH + 1)'(NUM_IN)) begin
            idx = SEL_WIDTH'(sum - (SEL_WIDTH + 1)'(NUM_IN));
        end else begin
            idx = sum[SEL_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin merge of NUM_IN FWFT FIFO heads onto one registered FIFO write port, burst-locked up to MAX_BURST.
// Latency: pop in cycle t, write strobe at edge t+1; optional stats (FIFO_RR_ARBITER_STATS_EN) read back with 1 cycle.
// Backpressure: out_full_n=0 stops pops but keeps the burst lock; downstream needs a grace period of at least one word.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter  int NUM_IN     = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 8,
    localparam int SEL_WIDTH  = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_IN-1:0]            in_empty_n,
    output logic [NUM_IN-1:0]            in_read,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
    input  logic                         out_full_n,
    output logic                         out_write,
    output logic [DATA_WIDTH-1:0]        out_din,
    output logic [SEL_WIDTH-1:0]         out_sel
`ifdef FIFO_RR_ARBITER_STATS_EN
    ,
    input  logic [SEL_WIDTH-1:0]         stat_sel,
    output logic [STAT_WIDTH-1:0]        stat_cnt
`endif
);

    localparam int BCW = $clog2(MAX_BURST + 1);

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0] owner_q, owner_d;
    logic [BCW-1:0]       cnt_q, cnt_d, cnt_inc;

    logic                  pick_found;
    logic [SEL_WIDTH-1:0]  pick_idx;
    logic [SEL_WIDTH-1:0]  grant;
    logic                  grant_vld;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] heads [NUM_IN];

    logic                  out_write_q;
    logic [DATA_WIDTH-1:0] out_din_q;
    logic [SEL_WIDTH-1:0]  out_sel_q;

    rr_priority_picker #(
        .NUM_IN (NUM_IN)
    ) u_picker (
        .req   (in_empty_n),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            heads[k] = in_dout[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + 1'b1;
        grant     = pick_idx;
        grant_vld = pick_found;
        if (state_q == BURST) begin
            grant     = owner_q;
            grant_vld = in_empty_n[owner_q];
        end
        xfer = grant_vld & out_full_n;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (MAX_BURST == 1) begin
                        ptr_d = SEL_WIDTH'(wrap_inc(32'(grant), NUM_IN));
                    end else begin
                        owner_d = grant;
                        cnt_d   = BCW'(1);
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                // An empty owner ends the lock; stalls from downstream do not.
                if (!in_empty_n[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = SEL_WIDTH'(wrap_inc(32'(owner_q), NUM_IN));
                    cnt_d   = '0;
                end else if (out_full_n) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BCW'(MAX_BURST)) begin
                        state_d = IDLE;
                        ptr_d   = SEL_WIDTH'(wrap_inc(32'(owner_q), NUM_IN));
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_read = '0;
        if (xfer && reset_n) begin
            in_read[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            out_write_q <= 1'b0;
            out_din_q   <= '0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            out_write_q <= xfer;
            if (xfer) begin
                out_din_q <= heads[grant];
                out_sel_q <= grant;
            end
        end
    end

    assign out_write = out_write_q;
    assign out_din   = out_din_q;
    assign out_sel   = out_sel_q;

`ifdef FIFO_RR_ARBITER_STATS_EN
    logic [STAT_WIDTH-1:0] stat_q [NUM_IN];
    logic [STAT_WIDTH-1:0] stat_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_IN; k++) begin
                stat_q[k] <= '0;
            end
            stat_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (in_read[k]) begin
                    stat_q[k] <= stat_q[k] + 1'b1;
                end
            end
            stat_cnt_q <= (32'(stat_sel) < NUM_IN) ? stat_q[stat_sel] : '0;
        end
    end

    assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomized and directed bench for fifo_rr_arbiter against a queue-based arbitration model.
// Sources are modelled as FWFT queues; outputs are checked every cycle at the falling edge.
module tb_fifo_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 2;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  in_empty_n;
    logic [N-1:0]  in_read;
    logic [N*DW-1:0] in_dout;
    logic          out_full_n;
    logic          out_write;
    logic [DW-1:0] out_din;
    logic [SW-1:0] out_sel;
`ifdef FIFO_RR_ARBITER_STATS_EN
    logic [SW-1:0] stat_sel;
    logic [31:0]   stat_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rr_arbiter #(
        .NUM_IN     (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_empty_n (in_empty_n),
        .in_read    (in_read),
        .in_dout    (in_dout),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din),
        .out_sel    (out_sel)
`ifdef FIFO_RR_ARBITER_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_cnt   (stat_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] src [N][$];
    bit            fn_drive;

    // Arbitration model: plain round-robin pointer plus a burst lock.
    int            m_ptr, m_owner, m_used;
    bit            m_locked;
    bit            e_w;
    logic [DW-1:0] e_din;
    int            e_sel;

    int rd_cnt [N];
    int log_w[$], log_s[$], log_r[$];
    logic [DW-1:0] log_d[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_used = 0; m_locked = 0;
        e_w = 0; e_din = '0; e_sel = 0;
        for (int k = 0; k < N; k++) rd_cnt[k] = 0;
        log_w.delete(); log_s.delete(); log_r.delete(); log_d.delete();
    endtask

    task automatic step();
        int g;
        bit x;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            in_empty_n[k] = (src[k].size() > 0);
            in_dout[k*DW +: DW] = (src[k].size() > 0) ? src[k][0] : '0;
        end
        out_full_n = fn_drive;
        #1;
        chk("out_write", {63'd0, out_write}, {63'd0, e_w});
        chk("out_din", {48'd0, out_din}, {48'd0, e_din});
        chk("out_sel", {62'd0, out_sel}, 64'(e_sel));
        log_w.push_back(int'(out_write));
        log_s.push_back(int'(out_sel));
        log_d.push_back(out_din);
        log_r.push_back(int'(in_read));

        x = 0;
        g = -1;
        if (!m_locked) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && src[(m_ptr + i) % N].size() > 0) g = (m_ptr + i) % N;
            end
            if (g >= 0 && fn_drive) begin
                x = 1;
                if (MB == 1) m_ptr = (g + 1) % N;
                else begin
                    m_locked = 1; m_owner = g; m_used = 1;
                end
            end
        end else if (src[m_owner].size() == 0) begin
            m_locked = 0;
            m_ptr = (m_owner + 1) % N;
        end else if (fn_drive) begin
            x = 1;
            g = m_owner;
            m_used++;
            if (m_used == MB) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end
        chk("in_read", {60'd0, in_read}, x ? (64'd1 << g) : 64'd0);
        for (int k = 0; k < N; k++) if (in_read[k]) rd_cnt[k]++;
        e_w = x;
        if (x) begin
            e_din = src[g].pop_front();
            e_sel = g;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        out_full_n = 1'b1;
        in_empty_n = '1;
        in_dout = '0;
        for (int k = 0; k < N; k++) src[k].delete();
        #1;
        chk("rst_out_write", {63'd0, out_write}, 64'd0);
        chk("rst_out_din", {48'd0, out_din}, 64'd0);
        chk("rst_out_sel", {62'd0, out_sel}, 64'd0);
        chk("rst_in_read", {60'd0, in_read}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        in_empty_n = '0;
        model_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        in_empty_n = '0;
        in_dout = '0;
        out_full_n = 1'b1;
        fn_drive = 1'b1;
`ifdef FIFO_RR_ARBITER_STATS_EN
        stat_sel = '0;
`endif
        model_reset();

        // Single requester: three words from requester 2.
        do_reset();
        for (int i = 0; i < 3; i++) src[2].push_back(16'hA201 + 16'(i));
        repeat (6) step();
        chk("s1_rd2", 64'(rd_cnt[2]), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("s1_read", 64'(log_r[i]), 64'h4);
            chk("s1_write", 64'(log_w[i+1]), 64'd1);
            chk("s1_sel", 64'(log_s[i+1]), 64'd2);
            chk("s1_data", {48'd0, log_d[i+1]}, 64'hA201 + 64'(i));
        end
        chk("s1_tail", 64'(log_w[4]), 64'd0);

        // All busy: bursts of two, no bubbles.
        do_reset();
        begin
            int exp_sel [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
            for (int k = 0; k < N; k++)
                for (int i = 0; i < 12; i++) src[k].push_back(16'((k << 8) | i));
            repeat (10) step();
            for (int i = 0; i < 8; i++) begin
                chk("s2_write", 64'(log_w[i+1]), 64'd1);
                chk("s2_sel", 64'(log_s[i+1]), 64'(exp_sel[i]));
            end
        end

        // Backpressure mid-burst of requester 1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src[1].push_back(16'h1100 + 16'(i));
            src[2].push_back(16'h2200 + 16'(i));
        end
        step();
        fn_drive = 1'b0;
        repeat (5) step();
        chk("s3_stall_pops", 64'(rd_cnt[1] + rd_cnt[2]), 64'd1);
        fn_drive = 1'b1;
        repeat (2) step();
        chk("s3_rd1", 64'(rd_cnt[1]), 64'(MB));
        chk("s3_rd2", 64'(rd_cnt[2]), 64'd1);
        for (int i = 0; i < 8; i++) step();

        // Owner drains after one word: bubble, then pointer wraps to 0.
        do_reset();
        src[2].push_back(16'h0201);
        src[2].push_back(16'h0202);
        src[3].push_back(16'h0301);
        repeat (2) step();
        src[0].push_back(16'h0001);
        src[0].push_back(16'h0002);
        repeat (3) step();
        begin
            int exp_r [5] = '{4, 4, 8, 0, 1};
            for (int i = 0; i < 5; i++) chk("s4_read", 64'(log_r[i]), 64'(exp_r[i]));
        end
        repeat (4) step();

        // Asynchronous reset between edges mid-burst.
        do_reset();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 6; i++) src[k].push_back(16'((k << 12) | 16'h0400 | i));
        repeat (3) step();
        @(posedge clk);
        #1;
        chk("s5_pre_write", {63'd0, out_write}, {63'd0, e_w});
        #1;
        reset_n = 1'b0;
        #1;
        chk("s5_arst_write", {63'd0, out_write}, 64'd0);
        chk("s5_arst_read", {60'd0, in_read}, 64'd0);
        @(negedge clk);
        in_empty_n = '0;
        reset_n = 1'b1;
        model_reset();
        step();
        chk("s5_first_grant", 64'(log_r[0]), 64'd1);
        repeat (20) step();

        // Random traffic with random downstream stalls.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 99) < 35 && src[k].size() < 6) src[k].push_back(16'($urandom));
            fn_drive = ($urandom_range(0, 9) < 8);
            step();
        end
        fn_drive = 1'b1;
        repeat (40) step();

`ifdef FIFO_RR_ARBITER_STATS_EN
        do_reset();
        for (int i = 0; i < 10; i++) src[1].push_back(16'h5100 + 16'(i));
        stat_sel = 1;
        repeat (14) step();
        chk("stat_cnt_1", {32'd0, stat_cnt}, 64'd10);
        stat_sel = 0;
        repeat (2) step();
        chk("stat_cnt_0", {32'd0, stat_cnt}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
